load_monitor: RTL and testbench

LOAD_MONITOR -- requirements
Module: load_monitor

---
 rtl/load_monitor.sv | 151 +++++++++++++++
 tb/tb_load_monitor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/load_monitor.sv
// load_monitor: locks onto a peak indication that is high 2 cycles and low 2N cycles.
// Define LOAD_MON_VOL_EST_EN to build the generator-volume reconstruction on vol_est.
module load_monitor #(
    parameter int N     = 12500,
    parameter int CBITS = 14,
    parameter int PBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    output logic             locked,
    output logic             err,
    output logic [7:0]       peak_cnt,
    output logic [CBITS-1:0] vol_est
);
    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    localparam logic [PBITS-1:0] K_ZERO    = {PBITS{1'b0}};
    localparam logic [PBITS-1:0] K_ONE     = PBITS'(1);
    localparam logic [PBITS-1:0] K_LOW_END = PBITS'(2 * N + 1);
    localparam logic [PBITS-1:0] K_PERIOD  = PBITS'(2 * N + 2);
    localparam logic [PBITS-1:0] K_MAX     = {PBITS{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [PBITS-1:0] k_r;
    logic [PBITS-1:0] k_inc_s;
    logic [PBITS-1:0] k_nx_s;
    logic [7:0]       peak_nx_s;
    logic             sig_q_r;
    logic             sig_v_r;
    logic             rise_s;
    logic             viol_s;

    // Rise detection and waveform check; k_inc_s is the position of the current edge in the period.
    // sig_v_r suppresses a false rise when sig is already high as reset releases.
    always_comb begin
        k_inc_s = (k_r == K_MAX) ? k_r : k_r + K_ONE;
        rise_s  = sig & ~sig_q_r & sig_v_r;
        viol_s  = 1'b0;
        if ((state_r == CHECK) || (state_r == TRACK)) begin
            if (k_inc_s == K_ONE) begin
                viol_s = ~sig;
            end else if (k_inc_s <= K_LOW_END) begin
                viol_s = sig;
            end else if (k_inc_s == K_PERIOD) begin
                viol_s = ~rise_s;
            end else begin
                viol_s = 1'b1;
            end
        end else begin
            viol_s = 1'b0;
        end
    end

    // Next-state, period counter and peak counter; a violation always beats a rise.
    always_comb begin
        state_nx_s = state_r;
        k_nx_s     = k_inc_s;
        peak_nx_s  = peak_cnt;
        case (state_r)
            HUNT, ERROR: begin
                if (rise_s) begin
                    state_nx_s = CHECK;
                    k_nx_s     = K_ZERO;
                end else begin
                    state_nx_s = state_r;
                    k_nx_s     = k_inc_s;
                end
            end
            CHECK, TRACK: begin
                if (viol_s) begin
                    state_nx_s = ERROR;
                end else if (k_inc_s == K_PERIOD) begin
                    state_nx_s = TRACK;
                    k_nx_s     = K_ZERO;
                    if (state_r == CHECK) begin
                        peak_nx_s = 8'd1;
                    end else if (peak_cnt != 8'hFF) begin
                        peak_nx_s = peak_cnt + 8'd1;
                    end else begin
                        peak_nx_s = peak_cnt;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = HUNT;
                k_nx_s     = K_ZERO;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= HUNT;
            k_r      <= K_ZERO;
            sig_q_r  <= 1'b0;
            sig_v_r  <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            peak_cnt <= 8'd0;
        end else begin
            state_r  <= state_nx_s;
            k_r      <= k_nx_s;
            sig_q_r  <= sig;
            sig_v_r  <= 1'b1;
            locked   <= (state_nx_s == TRACK);
            err      <= err | (state_nx_s == ERROR);
            peak_cnt <= peak_nx_s;
        end
    end

`ifdef LOAD_MON_VOL_EST_EN
    // Triangle reconstruction: falls from N to 0 over the first half, rises back over the second.
    function automatic logic [CBITS-1:0] vol_of(input logic [PBITS-1:0] k);
        logic [PBITS-1:0] v;
        if (k <= K_ONE) begin
            v = PBITS'(N);
        end else if (k <= PBITS'(N + 1)) begin
            v = PBITS'(N + 1) - k;
        end else if (k == PBITS'(N + 2)) begin
            v = K_ZERO;
        end else if (k <= K_LOW_END) begin
            v = k - PBITS'(N + 2);
        end else begin
            v = PBITS'(N);
        end
        return CBITS'(v);
    endfunction

    // Registered volume estimate, zero whenever no period is being followed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_est <= {CBITS{1'b0}};
        end else if ((state_nx_s == CHECK) || (state_nx_s == TRACK)) begin
            vol_est <= vol_of(k_nx_s);
        end else begin
            vol_est <= {CBITS{1'b0}};
        end
    end
`else
    assign vol_est = {CBITS{1'b0}};
`endif

endmodule

// File: tb/tb_load_monitor.sv
// Directed bench for load_monitor with N=4 (period 10); expected values are hand-derived.
module tb_load_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig = 1'b0;
    logic        locked;
    logic        err;
    logic [7:0]  peak_cnt;
    logic [13:0] vol_est;

    int vectors = 0;
    int miscompares = 0;

`ifdef LOAD_MON_VOL_EST_EN
    localparam bit VOL_ON = 1'b1;
`else
    localparam bit VOL_ON = 1'b0;
`endif

    bit [10:0] pat = 11'b100_0000_0011;
    int vol_tab [11] = '{4, 4, 3, 2, 1, 0, 0, 1, 2, 3, 4};

    load_monitor #(.N(4), .CBITS(14), .PBITS(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig      (sig),
        .locked   (locked),
        .err      (err),
        .peak_cnt (peak_cnt),
        .vol_est  (vol_est)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vx(input int v);
        return VOL_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic tick(input logic s);
        sig = s;
        @(posedge clk);
        #1;
    endtask

    // One period following an accepted rise: second high cycle, 8 lows, next rise.
    task automatic cont_period();
        tick(1'b1);
        repeat (8) tick(1'b0);
        tick(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        sig   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_peak", peak_cnt, 0);
        check("rst_vol", vol_est, 0);
        rst_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
        check("hunt_locked", locked, 0);

        for (int j = 0; j < 11; j++) begin
            tick(pat[j]);
            check($sformatf("vol_k%0d", j), vol_est, vx(vol_tab[j]));
            if (j == 9) check("lock_pre", locked, 0);
        end
        check("lock_2nd_rise", locked, 1);
        check("peak_2nd_rise", peak_cnt, 1);

        repeat (3) cont_period();
        check("peak_5th_rise", peak_cnt, 4);
        check("locked_5", locked, 1);
        check("err_5", err, 0);

        tick(1'b1);
        tick(1'b1);
        check("long_high_err", err, 1);
        check("long_high_locked", locked, 0);
        check("long_high_peak_hold", peak_cnt, 4);
        check("long_high_vol", vol_est, 0);
        repeat (3) tick(1'b0);
        tick(1'b1);
        check("resync_check_locked", locked, 0);
        check("resync_check_vol", vol_est, vx(4));
        cont_period();
        check("relock_locked", locked, 1);
        check("relock_peak", peak_cnt, 1);
        check("relock_err_sticky", err, 1);
        cont_period();
        check("relock_peak2", peak_cnt, 2);

        tick(1'b1);
        repeat (8) tick(1'b0);
        check("withhold_k9_locked", locked, 1);
        tick(1'b0);
        check("withhold_k10_locked", locked, 0);
        check("withhold_peak_hold", peak_cnt, 2);
        repeat (5) tick(1'b0);
        check("withhold_stay", locked, 0);
        tick(1'b1);
        cont_period();
        check("withhold_relock_peak", peak_cnt, 1);

        tick(1'b1);
        repeat (5) tick(1'b0);
        tick(1'b1);
        check("early_rise_locked", locked, 0);
        check("early_rise_vol", vol_est, 0);
        tick(1'b1);
        repeat (8) tick(1'b0);
        tick(1'b1);
        check("early_no_resync", locked, 0);
        cont_period();
        check("early_relock", locked, 1);

        repeat (260) cont_period();
        check("peak_saturate", peak_cnt, 255);
        check("sat_vol", vol_est, vx(4));

        tick(1'b1);
        repeat (3) tick(1'b0);
        sig = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_locked", locked, 0);
        check("async_err", err, 0);
        check("async_peak", peak_cnt, 0);
        check("async_vol", vol_est, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick(1'b1);
        check("held_high_err", err, 0);
        check("held_high_locked", locked, 0);
        check("held_high_vol", vol_est, 0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        check("post_rst_rise_vol", vol_est, vx(4));
        cont_period();
        check("post_rst_locked", locked, 1);
        check("post_rst_peak", peak_cnt, 1);
        check("post_rst_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
